// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data-memory responder with configurable wait states.
// Accepts a load/store request (MemRead/MemWrite) in IDLE, holds the pipeline via
// mem_stall for 1+WAIT_CYCLES cycles, then pulses mem_done for one cycle.
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   MemRead, MemWrite      request from EX/MEM (both high = store)
//   addr, wdata            byte address and store data
//   rdata                  registered load data (0 on misaligned / read+write)
//   mem_stall              combinational pipeline hold
//   mem_done, misaligned   one-cycle completion pulse and its misaligned flag
module dmem_responder #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_stall,
  output logic              mem_done,
  output logic              misaligned
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int AW = DEPTH_LOG2 + 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic              lat_rd, lat_wr;
  logic [AW-1:0]     lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  logic              req, accept, fire;
  logic              f_rd, f_wr, f_mis;
  logic [AW-1:0]     f_addr;
  logic [DATA_W-1:0] f_wdata;
  logic [DEPTH_LOG2-1:0] f_idx;

  // Upper address bits only select beyond the array; the index wraps.
  logic unused_addr;
  assign unused_addr = ^addr[31:AW];

  assign req    = MemRead | MemWrite;
  assign accept = (state == IDLE) && req;

  // With zero wait states the access happens on the acceptance edge itself,
  // so it must use the live inputs; otherwise the latched copies are used.
  assign fire    = (WAIT_CYCLES == 0) ? accept : ((state == BUSY) && (cnt == CW'(1)));
  assign f_rd    = (state == IDLE) ? MemRead       : lat_rd;
  assign f_wr    = (state == IDLE) ? MemWrite      : lat_wr;
  assign f_addr  = (state == IDLE) ? addr[AW-1:0]  : lat_addr;
  assign f_wdata = (state == IDLE) ? wdata         : lat_wdata;
  assign f_mis   = (f_addr[1:0] != 2'b00);
  assign f_idx   = f_addr[AW-1:2];

  assign mem_stall  = accept || (state == BUSY);
  assign mem_done   = (state == DONE);
  assign misaligned = mem_done && (lat_addr[1:0] != 2'b00);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_rd    <= 1'b0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          lat_rd    <= MemRead;
          lat_wr    <= MemWrite;
          lat_addr  <= addr[AW-1:0];
          lat_wdata <= wdata;
          cnt       <= CW'(WAIT_CYCLES);
          state     <= (WAIT_CYCLES == 0) ? DONE : BUSY;
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DONE;
        end
        // The request is still asserted here; it must not be re-accepted.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (fire) begin
        if (f_mis)      rdata <= '0;
        else if (f_wr) begin
          if (f_rd)     rdata <= '0;
        end else        rdata <= mem[f_idx];
      end
    end
  end

  // Array is not reset; the !reset gate keeps a store from landing while reset is held.
  always_ff @(posedge clock) begin
    if (fire && f_wr && !f_mis && !reset) mem[f_idx] <= f_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // dut2: WAIT_CYCLES=2, dut0: WAIT_CYCLES=0
  logic        rd2, wr2, rd0, wr0;
  logic [31:0] a2, d2, a0, d0;
  logic [31:0] q2, q0;
  logic        st2, dn2, mi2, st0, dn0, mi0;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.DATA_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut2 (
    .clock(clk), .reset(reset), .MemRead(rd2), .MemWrite(wr2), .addr(a2), .wdata(d2),
    .rdata(q2), .mem_stall(st2), .mem_done(dn2), .misaligned(mi2));

  dmem_responder #(.DATA_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
    .clock(clk), .reset(reset), .MemRead(rd0), .MemWrite(wr0), .addr(a0), .wdata(d0),
    .rdata(q0), .mem_stall(st0), .mem_done(dn0), .misaligned(mi0));

  // One access, request held until its DONE cycle passes. Starts at posedge+1.
  // lat = cycles before the mem_done cycle; stalls = cycles with mem_stall high.
  task automatic acc(input bit w0, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] q, output logic mis,
                     output int stalls, output int lat);
    bit done = 0;
    stalls = 0; lat = 0; q = 'x; mis = 1'bx;
    if (w0) begin rd0 = rd; wr0 = wr; a0 = a; d0 = d; end
    else    begin rd2 = rd; wr2 = wr; a2 = a; d2 = d; end
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (w0 ? st0 : st2) stalls++;
      if (w0 ? dn0 : dn2) begin
        done = 1; q = w0 ? q0 : q2; mis = w0 ? mi0 : mi2;
      end else lat++;
      @(posedge clk); #1;
    end
    rd0 = 0; wr0 = 0; rd2 = 0; wr2 = 0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout addr=%h got no mem_done required mem_done", a);
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({st2, dn2, mi2, q2} !== {3'b000, 32'h0}) begin
      errors++; $display("FAIL reset_dut2 got %b%b%b %h required 000 0", st2, dn2, mi2, q2);
    end
    checks++;
    if ({st0, dn0, mi0, q0} !== {3'b000, 32'h0}) begin
      errors++; $display("FAIL reset_dut0 got %b%b%b %h required 000 0", st0, dn0, mi0, q0);
    end
  endtask

  task automatic test_store_load;
    logic [31:0] q; logic mis; int s, l;
    acc(0, 0, 1, 32'h10, 32'hDEADBEEF, q, mis, s, l);
    checks++;
    if (s !== 3 || l !== 3 || mis !== 1'b0) begin
      errors++; $display("FAIL sw_timing got stalls=%0d lat=%0d mis=%b required 3 3 0", s, l, mis);
    end
    checks++;
    if (q !== 32'h0) begin errors++; $display("FAIL sw_rdata got %h required 0", q); end
    acc(0, 1, 0, 32'h10, 32'h0, q, mis, s, l);
    checks++;
    if (q !== 32'hDEADBEEF || l !== 3) begin
      errors++; $display("FAIL lw_0x10 got %h lat=%0d required deadbeef lat=3", q, l);
    end
    acc(0, 0, 1, 32'h14, 32'h5, q, mis, s, l);
    checks++;
    if (q !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sw_keeps_rdata got %h required deadbeef", q);
    end
  endtask

  task automatic test_misaligned;
    logic [31:0] q; logic mis; int s, l;
    acc(0, 1, 0, 32'h13, 32'h0, q, mis, s, l);
    checks++;
    if (mis !== 1'b1 || q !== 32'h0 || l !== 3 || s !== 3) begin
      errors++; $display("FAIL lw_misaligned got mis=%b q=%h lat=%0d stalls=%0d required 1 0 3 3", mis, q, l, s);
    end
    acc(0, 1, 0, 32'h10, 32'h0, q, mis, s, l);
    checks++;
    if (q !== 32'hDEADBEEF || mis !== 1'b0) begin
      errors++; $display("FAIL reread_0x10 got %h mis=%b required deadbeef 0", q, mis);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] q; logic mis; int s, l;
    acc(0, 0, 1, 32'h10, 32'h1, q, mis, s, l);
    acc(0, 0, 1, 32'h1010, 32'h2, q, mis, s, l);
    acc(0, 1, 0, 32'h10, 32'h0, q, mis, s, l);
    checks++;
    if (q !== 32'h2) begin errors++; $display("FAIL index_wrap got %h required 2", q); end
  endtask

  task automatic test_read_write;
    logic [31:0] q; logic mis; int s, l;
    acc(0, 1, 1, 32'h8, 32'h7, q, mis, s, l);
    checks++;
    if (q !== 32'h0) begin errors++; $display("FAIL rw_rdata got %h required 0", q); end
    acc(0, 1, 0, 32'h8, 32'h0, q, mis, s, l);
    checks++;
    if (q !== 32'h7) begin errors++; $display("FAIL rw_store got %h required 7", q); end
  endtask

  task automatic test_reset_busy;
    logic [31:0] q; logic mis; int s, l;
    acc(0, 0, 1, 32'h20, 32'h11, q, mis, s, l);
    rd2 = 0; wr2 = 1; a2 = 32'h20; d2 = 32'h5;
    @(posedge clk); #1;
    rd2 = 0; wr2 = 0;
    @(negedge clk);
    checks++;
    if (st2 !== 1'b1) begin errors++; $display("FAIL busy_stall got %b required 1", st2); end
    #1 reset = 1;
    #1;
    checks++;
    if ({st2, dn2, mi2, q2} !== {3'b000, 32'h0}) begin
      errors++; $display("FAIL async_reset got %b%b%b %h required 000 0", st2, dn2, mi2, q2);
    end
    @(posedge clk); #1 reset = 0;
    acc(0, 1, 0, 32'h20, 32'h0, q, mis, s, l);
    checks++;
    if (q !== 32'h11 || l !== 3) begin
      errors++; $display("FAIL after_reset got %h lat=%0d required 11 lat=3", q, l);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] q; logic mis; int s, l;
    acc(1, 0, 1, 32'h4, 32'hA5, q, mis, s, l);
    checks++;
    if (s !== 1 || l !== 1) begin
      errors++; $display("FAIL w0_sw got stalls=%0d lat=%0d required 1 1", s, l);
    end
    acc(1, 1, 0, 32'h4, 32'h0, q, mis, s, l);
    checks++;
    if (q !== 32'hA5 || s !== 1 || l !== 1) begin
      errors++; $display("FAIL w0_lw got %h stalls=%0d lat=%0d required a5 1 1", q, s, l);
    end
    @(negedge clk);
    checks++;
    if (dn0 !== 1'b0 || st0 !== 1'b0) begin
      errors++; $display("FAIL w0_single_done got done=%b stall=%b required 0 0", dn0, st0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1;
    rd2 = 0; wr2 = 0; a2 = 0; d2 = 0;
    rd0 = 0; wr0 = 0; a0 = 0; d0 = 0;
    repeat (2) @(posedge clk);
    #1 test_reset();
    reset = 0;
    test_store_load();
    test_misaligned();
    test_wrap();
    test_read_write();
    test_reset_busy();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
